// File: rtl/uart_rx.sv
// 8N1 RS232 receiver: 2-FF synchroniser, mid-bit 3-sample majority vote.
// Ports: clk, rst_n, rs232_rx, fifo232_full -> rx_data, fifo232_wrreq, frame_err, overrun, rx_busy.
module uart_rx #(
  parameter int CLK_HZ = 20000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       fifo232_full,
  output logic [7:0] rx_data,
  output logic       fifo232_wrreq,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC);

  localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_A    = CW'(HALF - 1);
  localparam logic [CW-1:0] C_B    = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;
  logic            smp_a;
  logic            smp_b;
  logic            fall;
  logic            maj;
  logic            dec;

  assign fall = prev & ~sync2;
  // third vote is the live synced value at the decision cycle
  assign maj  = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
  assign dec  = (cnt == C_DEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      prev          <= 1'b1;
      cnt           <= '0;
      bidx          <= '0;
      shreg         <= '0;
      smp_a         <= 1'b1;
      smp_b         <= 1'b1;
      rx_data       <= '0;
      fifo232_wrreq <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      sync1         <= rs232_rx;
      sync2         <= sync1;
      prev          <= sync2;
      fifo232_wrreq <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;

      if (state == IDLE || cnt == C_LAST) cnt <= '0;
      else cnt <= cnt + 1'b1;

      if (cnt == C_A) smp_a <= sync2;
      if (cnt == C_B) smp_b <= sync2;

      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (dec) begin
            if (maj) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
              bidx  <= '0;
            end
          end
        end
        DATA: begin
          if (dec) begin
            shreg[bidx] <= maj;
            bidx        <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (dec) begin
            if (maj) begin
              rx_data <= shreg;
              if (!fifo232_full) fifo232_wrreq <= 1'b1;
              else overrun <= 1'b1;
              // leave mid-stop so a back-to-back start edge is seen
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (sync2) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_CYC=16, HALF=8.
// Ports: drives clk/rst_n/rs232_rx/fifo232_full, watches all outputs.
module tb_uart_rx;

  localparam int BC = 16;
  localparam int LAT = 9 * BC + 8 + 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rs232_rx;
  logic       fifo232_full;
  logic [7:0] rx_data;
  logic       fifo232_wrreq;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  int n_wr = 0, n_fe = 0, n_ov = 0, n_excl = 0;
  int b_wr, b_fe, b_ov;
  int wr_cyc = 0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] wr_data1 = 8'h00;
  logic wr_busy = 1'b1;

  uart_rx #(.CLK_HZ(1600000), .BAUD(100000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs232_rx(rs232_rx),
    .fifo232_full(fifo232_full),
    .rx_data(rx_data),
    .fifo232_wrreq(fifo232_wrreq),
    .frame_err(frame_err),
    .overrun(overrun),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fifo232_wrreq) begin
      n_wr++;
      wr_data1 = wr_data;
      wr_data = rx_data;
      wr_cyc = cyc;
      wr_busy = rx_busy;
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if ((fifo232_wrreq && overrun) ||
        (frame_err && (fifo232_wrreq || overrun)))
      n_excl++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = n_wr;
    b_fe = n_fe;
    b_ov = n_ov;
  endtask

  task automatic hold(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stp,
                      input int spike);
    t_start = cyc;
    hold(1'b0, BC);
    for (int i = 0; i < 8; i++) begin
      if (i == spike) begin
        hold(d[i], 8);
        hold(~d[i], 1);
        hold(d[i], BC - 9);
      end else begin
        hold(d[i], BC);
      end
    end
    hold(stp, BC);
  endtask

  initial begin
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    fifo232_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_wr", fifo232_wrreq, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    snap();
    hold(1'b0, 4);
    check("gl_busy", rx_busy, 1'b1);
    hold(1'b1, 40);
    check("gl_idle", rx_busy, 1'b0);
    check("gl_wr", n_wr - b_wr, 0);
    check("gl_fe", n_fe - b_fe, 0);
    check("gl_ov", n_ov - b_ov, 0);
    check("gl_data", rx_data, 8'h00);

    snap();
    send(8'h55, 1'b1, -1);
    hold(1'b1, 20);
    check("f55_wr", n_wr - b_wr, 1);
    check("f55_data", wr_data, 8'h55);
    check("f55_lat", wr_cyc - t_start, LAT);
    check("f55_busy", wr_busy, 1'b0);
    check("f55_fe", n_fe - b_fe, 0);
    check("f55_ov", n_ov - b_ov, 0);

    snap();
    send(8'hA3, 1'b0, -1);
    hold(1'b0, 40);
    check("fe_cnt", n_fe - b_fe, 1);
    check("fe_wr", n_wr - b_wr, 0);
    check("fe_data", rx_data, 8'h55);
    check("fe_brk", rx_busy, 1'b1);
    hold(1'b1, 20);
    check("fe_idle", rx_busy, 1'b0);
    snap();
    send(8'h3C, 1'b1, -1);
    hold(1'b1, 20);
    check("f3c_wr", n_wr - b_wr, 1);
    check("f3c_data", wr_data, 8'h3C);

    snap();
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    hold(1'b1, 20);
    check("b2b_wr", n_wr - b_wr, 2);
    check("b2b_d0", wr_data1, 8'h00);
    check("b2b_d1", wr_data, 8'hFF);

    snap();
    send(8'h81, 1'b1, 0);
    hold(1'b1, 20);
    check("spk_wr", n_wr - b_wr, 1);
    check("spk_data", wr_data, 8'h81);

    snap();
    fifo232_full = 1'b1;
    send(8'h7E, 1'b1, -1);
    hold(1'b1, 20);
    fifo232_full = 1'b0;
    check("ovr_cnt", n_ov - b_ov, 1);
    check("ovr_wr", n_wr - b_wr, 0);
    check("ovr_data", rx_data, 8'h7E);

    snap();
    hold(1'b0, BC);
    hold(1'b0, BC);
    hold(1'b1, BC);
    hold(1'b0, 5);
    check("mid_busy", rx_busy, 1'b1);
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    #1;
    check("mr_data", rx_data, 8'h00);
    check("mr_busy", rx_busy, 1'b0);
    check("mr_wr", fifo232_wrreq, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 10);
    send(8'hC4, 1'b1, -1);
    hold(1'b1, 20);
    check("fc4_wr", n_wr - b_wr, 1);
    check("fc4_data", wr_data, 8'hC4);
    check("fc4_fe", n_fe - b_fe, 0);

    check("excl", n_excl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
